column_scorer: RTL and testbench

- Downstream consumer of one note column's five light cells (L0..L4).
- Conditions the raw player button into the single-cycle KEY pulse the cells sample.
- Registers TOP_POS, the position of the lit light nearest the hit zone, which feeds back to the cells.
- Sums the cells' signed point outputs each cycle into a saturating column score, and tracks current and best combo.

---
 rtl/column_scorer_if.sv | 32 +++
 rtl/column_scorer.sv | 120 ++++++++++++
 tb/tb_column_scorer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/column_scorer_if.sv
`default_nettype none
// ============================================================================
// Module   : column_scorer_if
// Brief    : Cell-side bus of one note column: run/key/lights/points in,
//            conditioned key, top position, score and combo out.
// Revision : 1.0 - initial release
// ============================================================================
interface column_scorer_if #(
  parameter int SCORE_W = 10,
  parameter int COMBO_W = 6
);
  logic                      run;
  logic                      KEY_RAW;
  logic [4:0]                LIGHTS;
  logic [19:0]               PTS;
  logic                      KEY;
  logic [2:0]                TOP_POS;
  logic signed [SCORE_W-1:0] score;
  logic [COMBO_W-1:0]        combo;
  logic [COMBO_W-1:0]        best_combo;

  modport master (
    output run, KEY_RAW, LIGHTS, PTS,
    input  KEY, TOP_POS, score, combo, best_combo
  );

  modport slave (
    input  run, KEY_RAW, LIGHTS, PTS,
    output KEY, TOP_POS, score, combo, best_combo
  );
endinterface
`default_nettype wire

// File: rtl/column_scorer.sv
`default_nettype none
// ============================================================================
// Module   : column_scorer
// Brief    : Key conditioning, top-light encode, saturating score and combo
//            tracking for one note column of five light cells.
// Revision : 1.0 - initial release
// ============================================================================
module column_scorer #(
  parameter int SCORE_W = 10,
  parameter int COMBO_W = 6
) (
  input wire logic        clk,
  input wire logic        rst_n,
  column_scorer_if.slave  bus
);

  localparam logic signed [SCORE_W-1:0] c_SCORE_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] c_SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [COMBO_W-1:0]        c_COMBO_MAX = {COMBO_W{1'b1}};

  logic                      r_s1;
  logic                      r_s2;
  logic                      r_s3;
  logic                      r_key;
  logic [2:0]                r_top_pos;
  logic signed [SCORE_W-1:0] r_score;
  logic [COMBO_W-1:0]        r_combo;
  logic [COMBO_W-1:0]        r_best;

  logic signed [6:0]         w_nib [5];
  logic signed [6:0]         w_sum;
  logic signed [SCORE_W:0]   w_sum_ext;
  logic signed [SCORE_W:0]   w_acc;
  logic signed [SCORE_W-1:0] w_score_next;
  logic [COMBO_W-1:0]        w_combo_next;
  logic [2:0]                w_top_pos;
  logic                      w_sum_pos;
  logic                      w_sum_neg;

  // Sign-extend each cell's 4-bit point nibble to the 7-bit sum width.
  for (genvar gi = 0; gi < 5; gi++) begin : g_nib
    assign w_nib[gi] = {{3{bus.PTS[4*gi+3]}}, bus.PTS[4*gi +: 4]};
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 5; i++) begin
      w_sum = w_sum + w_nib[i];
    end
  end

  assign w_sum_neg = w_sum[6];
  assign w_sum_pos = ~w_sum[6] & (|w_sum);
  assign w_sum_ext = {{(SCORE_W-6){w_sum[6]}}, w_sum};
  assign w_acc     = {r_score[SCORE_W-1], r_score} + w_sum_ext;

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    w_score_next = w_acc[SCORE_W-1:0];
    if (w_acc[SCORE_W] != w_acc[SCORE_W-1]) begin
      w_score_next = w_acc[SCORE_W] ? c_SCORE_MIN : c_SCORE_MAX;
    end
  end

  always_comb begin
    w_combo_next = r_combo;
    if (w_sum_pos) begin
      if (r_combo != c_COMBO_MAX) begin
        w_combo_next = r_combo + 1'b1;
      end
    end else if (w_sum_neg) begin
      w_combo_next = '0;
    end
  end

  // Evaluated high-to-low so the lowest lit index wins.
  always_comb begin
    w_top_pos = 3'd0;
    if (bus.LIGHTS[4]) w_top_pos = 3'd5;
    if (bus.LIGHTS[3]) w_top_pos = 3'd4;
    if (bus.LIGHTS[2]) w_top_pos = 3'd3;
    if (bus.LIGHTS[1]) w_top_pos = 3'd2;
    if (bus.LIGHTS[0]) w_top_pos = 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_key     <= 1'b0;
      r_top_pos <= 3'd0;
      r_score   <= '0;
      r_combo   <= '0;
      r_best    <= '0;
    end else begin
      r_s1      <= bus.KEY_RAW;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      // s3 keeps tracking while stopped, so a rise during run=0 is consumed.
      r_key     <= bus.run & r_s2 & ~r_s3;
      r_top_pos <= w_top_pos;
      if (bus.run) begin
        r_score <= w_score_next;
        r_combo <= w_combo_next;
        if (w_combo_next > r_best) begin
          r_best <= w_combo_next;
        end
      end
    end
  end

  assign bus.KEY        = r_key;
  assign bus.TOP_POS    = r_top_pos;
  assign bus.score      = r_score;
  assign bus.combo      = r_combo;
  assign bus.best_combo = r_best;

endmodule
`default_nettype wire

// File: tb/tb_column_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tb_column_scorer
// Brief    : Directed self-checking bench for column_scorer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_column_scorer;

  localparam int c_SCORE_W = 10;
  localparam int c_COMBO_W = 6;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cnt;
  int   first;

  column_scorer_if #(.SCORE_W(c_SCORE_W), .COMBO_W(c_COMBO_W)) bus ();

  column_scorer #(.SCORE_W(c_SCORE_W), .COMBO_W(c_COMBO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4);
    logic [3:0] n0, n1, n2, n3, n4;
    n0 = a0[3:0]; n1 = a1[3:0]; n2 = a2[3:0]; n3 = a3[3:0]; n4 = a4[3:0];
    return {n4, n3, n2, n1, n0};
  endfunction

  // Press KEY_RAW for 'hold' edges, observe 'window' edges; count KEY pulses.
  task automatic press(input int hold, input int window, output int c, output int f);
    c = 0;
    f = 0;
    bus.KEY_RAW = 1'b1;
    for (int i = 1; i <= window; i++) begin
      tick();
      if (i == hold) bus.KEY_RAW = 1'b0;
      if (bus.KEY) begin
        c++;
        if (f == 0) f = i;
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.run     = 1'b1;
    bus.KEY_RAW = 1'b1;
    bus.LIGHTS  = 5'b11111;
    bus.PTS     = '0;

    // Reset held through edges with the button down and all lights on
    tick();
    tick();
    check("rst_key",   int'(bus.KEY), 0);
    check("rst_top",   int'(bus.TOP_POS), 0);
    check("rst_score", int'($signed(bus.score)), 0);
    check("rst_combo", int'(bus.combo), 0);
    check("rst_best",  int'(bus.best_combo), 0);

    rst_n = 1'b1;
    tick();
    check("rel_top_e1", int'(bus.TOP_POS), 1);
    check("rel_key_e1", int'(bus.KEY), 0);
    tick();
    check("rel_key_e2", int'(bus.KEY), 0);
    tick();
    check("rel_key_e3", int'(bus.KEY), 1);
    tick();
    check("rel_key_e4", int'(bus.KEY), 0);

    // Key pulse: long press, second press, press while stopped
    bus.KEY_RAW = 1'b0;
    repeat (4) tick();
    press(10, 14, cnt, first);
    check("press1_count", cnt, 1);
    check("press1_edge",  first, 3);
    repeat (4) tick();
    press(2, 8, cnt, first);
    check("press2_count", cnt, 1);
    check("press2_edge",  first, 3);
    repeat (4) tick();
    bus.run = 1'b0;
    press(20, 6, cnt, first);
    check("press_stopped", cnt, 0);
    bus.run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.KEY) cnt++;
    end
    check("press_deferred", cnt, 0);
    bus.KEY_RAW = 1'b0;
    repeat (4) tick();

    // Priority encode, one-cycle latency
    bus.LIGHTS = 5'b10100;
    check("top_no_comb", int'(bus.TOP_POS), 1);
    tick();
    check("top_10100", int'(bus.TOP_POS), 3);
    bus.LIGHTS = 5'b10000;
    tick();
    check("top_10000", int'(bus.TOP_POS), 5);
    bus.LIGHTS = 5'b00000;
    tick();
    check("top_00000", int'(bus.TOP_POS), 0);
    bus.LIGHTS = 5'b01010;
    tick();
    check("top_01010", int'(bus.TOP_POS), 2);

    // Accumulate
    bus.PTS = pk(2, -2, 0, 0, 0);
    tick();
    check("mix_score", int'($signed(bus.score)), 0);
    check("mix_combo", int'(bus.combo), 0);
    bus.PTS = pk(2, 0, 0, 0, 0);
    repeat (3) tick();
    check("pos3_score", int'($signed(bus.score)), 6);
    check("pos3_combo", int'(bus.combo), 3);
    check("pos3_best",  int'(bus.best_combo), 3);
    bus.PTS = pk(3, -1, -2, 0, 0);
    tick();
    check("zero_score", int'($signed(bus.score)), 6);
    check("zero_combo", int'(bus.combo), 3);
    bus.PTS = pk(0, 0, -2, 0, 0);
    tick();
    check("neg_score", int'($signed(bus.score)), 4);
    check("neg_combo", int'(bus.combo), 0);
    check("neg_best",  int'(bus.best_combo), 3);

    // Saturation high: +35 per cycle from 4
    bus.PTS = pk(7, 7, 7, 7, 7);
    repeat (20) tick();
    check("sat_hi_score", int'($signed(bus.score)), 511);
    check("sat_hi_combo", int'(bus.combo), 20);
    tick();
    check("sat_hi_hold", int'($signed(bus.score)), 511);

    // Saturation low: -40 per cycle
    bus.PTS = pk(-8, -8, -8, -8, -8);
    repeat (30) tick();
    check("sat_lo_score", int'($signed(bus.score)), -512);
    check("sat_lo_combo", int'(bus.combo), 0);
    check("sat_lo_best",  int'(bus.best_combo), 21);

    // Combo saturation: +1 for 70 cycles from -512
    bus.PTS = pk(1, 0, 0, 0, 0);
    repeat (70) tick();
    check("combo_sat",       int'(bus.combo), 63);
    check("combo_sat_best",  int'(bus.best_combo), 63);
    check("combo_sat_score", int'($signed(bus.score)), -442);

    // Freeze with run low; TOP_POS still tracks
    bus.run    = 1'b0;
    bus.PTS    = pk(-8, 0, 0, 0, 0);
    bus.LIGHTS = 5'b01000;
    repeat (3) tick();
    check("frz_score", int'($signed(bus.score)), -442);
    check("frz_combo", int'(bus.combo), 63);
    check("frz_best",  int'(bus.best_combo), 63);
    check("frz_top",   int'(bus.TOP_POS), 4);

    // Asynchronous reset away from any clock edge
    rst_n = 1'b0;
    #2;
    check("arst_score", int'($signed(bus.score)), 0);
    check("arst_best",  int'(bus.best_combo), 0);
    check("arst_top",   int'(bus.TOP_POS), 0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
